seg_chaser_ctrl: RTL and testbench

//  Upstream sequencer for the 8-way segment demux stage: generates its data bit In and select S[2:0].

---
 rtl/seg_chaser_pkg.sv | 20 ++
 rtl/seg_tick_prescaler.sv | 33 +++
 rtl/seg_chaser_ctrl.sv | 158 +++++++++++++++
 tb/tb_seg_chaser_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_chaser_pkg.sv
// Shared types and constants for the segment chaser sequencer.
package seg_chaser_pkg;

  localparam int NUM_POS = 8;
  localparam int POS_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [POS_W-1:0] step_pos(
    input logic [POS_W-1:0] pos,
    input logic             dir
  );
    return dir ? pos - POS_W'(1) : pos + POS_W'(1);
  endfunction

endpackage

// File: rtl/seg_tick_prescaler.sv
// Step-rate prescaler: one-cycle Tick every TICK_DIV enabled clocks.
module seg_tick_prescaler #(
  parameter int TICK_DIV = 5_000_000,
  parameter int DIV_W    = 23
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clr,
  input  logic En,
  output logic Tick
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign Tick = En && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (Clr) begin
      cnt_d = '0;
    end else if (En) begin
      cnt_d = Tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_chaser_ctrl.sv
// Segment chaser sequencer driving the 8-way demux select S and data In.
// Optional bounce mode: define SEG_CHASER_BOUNCE_EN.
module seg_chaser_ctrl
  import seg_chaser_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000,
  parameter int DIV_W    = 23,
  parameter int LOOPS    = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Dir,
  input  logic [7:0]       Mask,
`ifdef SEG_CHASER_BOUNCE_EN
  input  logic             Bounce,
`endif
  output logic             In,
  output logic [POS_W-1:0] S,
  output logic             Busy,
  output logic             Done
);

  localparam int LOOP_W = $clog2(LOOPS) + 1;
  localparam int LAST_I = (LOOPS > 0) ? LOOPS - 1 : 0;
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LAST_I);
  localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(NUM_POS - 1);

  state_e            state_q, state_d;
  logic [POS_W-1:0]  s_q, s_d;
  logic              dir_q, dir_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic              in_q, in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic tick, pre_clr, pre_en;
  logic at_end, pass_end, last_pass, rev;

`ifdef SEG_CHASER_BOUNCE_EN
  logic bnc_q, bnc_d;
  logic sdir_q, sdir_d;
`endif

  seg_tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_presc (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (pre_clr),
    .En    (pre_en),
    .Tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    dir_d   = dir_q;
    loop_d  = loop_q;
    pre_clr = 1'b0;
    pre_en  = 1'b0;
    at_end  = dir_q ? (s_q == '0) : (s_q == POS_MAX);
`ifdef SEG_CHASER_BOUNCE_EN
    bnc_d   = bnc_q;
    sdir_d  = sdir_q;
    // a bounce pass ends only after the return leg reaches home
    pass_end = at_end && (!bnc_q || (dir_q != sdir_q));
    rev      = at_end && bnc_q;
`else
    pass_end = at_end;
    rev      = 1'b0;
`endif
    last_pass = (LOOPS != 0) && (loop_q == LOOP_LAST);

    unique case (state_q)
      ST_IDLE: begin
        pre_clr = 1'b1;
        if (Start && !Stop) begin
          state_d = ST_RUN;
          s_d     = Dir ? POS_MAX : '0;
          dir_d   = Dir;
          loop_d  = '0;
`ifdef SEG_CHASER_BOUNCE_EN
          bnc_d   = Bounce;
          sdir_d  = Dir;
`endif
        end
      end
      ST_RUN: begin
        if (Stop) begin
          state_d = ST_IDLE;
          pre_clr = 1'b1;
          loop_d  = '0;
        end else begin
          pre_en = 1'b1;
          if (tick) begin
            if (pass_end && last_pass) begin
              state_d = ST_DONE;
            end else begin
              if (pass_end) loop_d = loop_q + LOOP_W'(1);
              dir_d = dir_q ^ rev;
              s_d   = step_pos(s_q, dir_d);
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        pre_clr = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    in_d   = busy_d && Mask[s_d];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      dir_q   <= 1'b0;
      loop_q  <= '0;
      in_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      dir_q   <= dir_d;
      loop_q  <= loop_d;
      in_q    <= in_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SEG_CHASER_BOUNCE_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bnc_q  <= 1'b0;
      sdir_q <= 1'b0;
    end else begin
      bnc_q  <= bnc_d;
      sdir_q <= sdir_d;
    end
  end
`endif

  assign S    = s_q;
  assign In   = in_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_seg_chaser_ctrl.sv
// Directed self-checking bench for seg_chaser_ctrl (LOOPS=0/1/2 instances).
module tb_seg_chaser_ctrl;

  logic       Clk;
  logic       Reset, Start, Stop, Dir;
  logic [7:0] Mask;
`ifdef SEG_CHASER_BOUNCE_EN
  logic       Bounce;
`endif

  logic       in1, busy1, done1;
  logic [2:0] s1;
  logic       in0, busy0, done0;
  logic [2:0] s0;
  logic       in2, busy2, done2;
  logic [2:0] s2;

  int n_checks;
  int n_fail;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  seg_chaser_ctrl #(.TICK_DIV(4), .DIV_W(3), .LOOPS(1)) u1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop),
    .Dir(Dir), .Mask(Mask),
`ifdef SEG_CHASER_BOUNCE_EN
    .Bounce(Bounce),
`endif
    .In(in1), .S(s1), .Busy(busy1), .Done(done1)
  );

  seg_chaser_ctrl #(.TICK_DIV(4), .DIV_W(3), .LOOPS(0)) u0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop),
    .Dir(Dir), .Mask(Mask),
`ifdef SEG_CHASER_BOUNCE_EN
    .Bounce(Bounce),
`endif
    .In(in0), .S(s0), .Busy(busy0), .Done(done0)
  );

  seg_chaser_ctrl #(.TICK_DIV(4), .DIV_W(3), .LOOPS(2)) u2 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop),
    .Dir(Dir), .Mask(Mask),
`ifdef SEG_CHASER_BOUNCE_EN
    .Bounce(Bounce),
`endif
    .In(in2), .S(s2), .Busy(busy2), .Done(done2)
  );

`ifdef SEG_CHASER_BOUNCE_EN
  logic       inb, busyb, doneb;
  logic [2:0] sb;

  seg_chaser_ctrl #(.TICK_DIV(2), .DIV_W(2), .LOOPS(1)) ub (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop),
    .Dir(Dir), .Mask(Mask), .Bounce(Bounce),
    .In(inb), .S(sb), .Busy(busyb), .Done(doneb)
  );
`endif

  task automatic do_reset();
    Start = 1'b0;
    Stop  = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b0;
    Stop  = 1'b0;
    Dir   = 1'b0;
    Mask  = 8'hFF;
    repeat (2) @(negedge Clk);
    n_checks++;
    if ({s1, in1, busy1, done1} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: got S=%0d In=%b Busy=%b Done=%b want 0 0 0 0",
               s1, in1, busy1, done1);
    end
    Reset = 1'b0;
    @(negedge Clk);
    start_pulse();
    repeat (20) @(negedge Clk);
    n_checks++;
    if (s1 !== 3'd5 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_s5: got S=%0d Busy=%b want S=5 Busy=1", s1, busy1);
    end
    Reset = 1'b1;
    Start = 1'b1;
    @(negedge Clk);
    n_checks++;
    if ({s1, in1, busy1, done1} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: got S=%0d In=%b Busy=%b Done=%b want 0 0 0 0",
               s1, in1, busy1, done1);
    end
    Reset = 1'b0;
    Start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_ascend();
    logic [2:0] exp_s;
    do_reset();
    Dir  = 1'b0;
    Mask = 8'hFF;
    start_pulse();
    for (int k = 0; k < 32; k++) begin
      exp_s = 3'(k / 4);
      n_checks++;
      if (s1 !== exp_s || in1 !== 1'b1 || busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_fail++;
        $display("FAIL ascend_k%0d: got S=%0d In=%b Busy=%b Done=%b want S=%0d 1 1 0",
                 k, s1, in1, busy1, done1, exp_s);
      end
      @(negedge Clk);
    end
    n_checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || in1 !== 1'b0 || s1 !== 3'd7) begin
      n_fail++;
      $display("FAIL ascend_done: got Done=%b Busy=%b In=%b S=%0d want 1 0 0 7",
               done1, busy1, in1, s1);
    end
    @(negedge Clk);
    n_checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || s1 !== 3'd7) begin
      n_fail++;
      $display("FAIL ascend_idle: got Done=%b Busy=%b S=%0d want 0 0 7",
               done1, busy1, s1);
    end
  endtask

  task automatic test_descend_mask();
    logic [2:0] exp_s;
    logic       exp_in;
    do_reset();
    Dir  = 1'b1;
    Mask = 8'b1010_1010;
    start_pulse();
    for (int k = 0; k < 32; k++) begin
      exp_s  = 3'(7 - k / 4);
      exp_in = exp_s[0];
      n_checks++;
      if (s1 !== exp_s || in1 !== exp_in || busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_fail++;
        $display("FAIL descend_k%0d: got S=%0d In=%b Busy=%b Done=%b want S=%0d In=%b 1 0",
                 k, s1, in1, busy1, done1, exp_s, exp_in);
      end
      if (k == 10) begin
        Dir   = 1'b0;
        Start = 1'b1;
      end
      if (k == 11) Start = 1'b0;
      @(negedge Clk);
    end
    n_checks++;
    if (done1 !== 1'b1 || s1 !== 3'd0 || in1 !== 1'b0) begin
      n_fail++;
      $display("FAIL descend_done: got Done=%b S=%0d In=%b want 1 0 0",
               done1, s1, in1);
    end
  endtask

  task automatic test_stop();
    logic [2:0] exp_s;
    do_reset();
    Dir  = 1'b0;
    Mask = 8'hFF;
    start_pulse();
    for (int k = 0; k <= 50; k++) begin
      exp_s = 3'((k / 4) % 8);
      n_checks++;
      if (s0 !== exp_s || busy0 !== 1'b1 || done0 !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_run_k%0d: got S=%0d Busy=%b Done=%b want S=%0d 1 0",
                 k, s0, busy0, done0, exp_s);
      end
      if (k < 50) @(negedge Clk);
    end
    Stop = 1'b1;
    @(negedge Clk);
    Stop = 1'b0;
    n_checks++;
    if (busy0 !== 1'b0 || in0 !== 1'b0 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_idle: got Busy=%b In=%b Done=%b want 0 0 0",
               busy0, in0, done0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      n_checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_nodone_%0d: got Busy=%b Done=%b want 0 0",
                 k, busy0, done0);
      end
    end
    Start = 1'b1;
    Stop  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      n_checks++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
        n_fail++;
        $display("FAIL start_stop_%0d: got Busy=%b%b%b want 000",
                 k, busy0, busy1, busy2);
      end
    end
    Start = 1'b0;
    Stop  = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_s;
    do_reset();
    Dir   = 1'b0;
    Mask  = 8'hFF;
    Start = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 64; k++) begin
      exp_s = 3'((k / 4) % 8);
      n_checks++;
      if (s2 !== exp_s || busy2 !== 1'b1 || done2 !== 1'b0) begin
        n_fail++;
        $display("FAIL loops2_k%0d: got S=%0d Busy=%b Done=%b want S=%0d 1 0",
                 k, s2, busy2, done2, exp_s);
      end
      @(negedge Clk);
    end
    n_checks++;
    if (done2 !== 1'b1 || s2 !== 3'd7) begin
      n_fail++;
      $display("FAIL loops2_done: got Done=%b S=%0d want 1 7", done2, s2);
    end
    @(negedge Clk);
    n_checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || s2 !== 3'd7) begin
      n_fail++;
      $display("FAIL loops2_gap: got Busy=%b Done=%b S=%0d want 0 0 7",
               busy2, done2, s2);
    end
    @(negedge Clk);
    n_checks++;
    if (busy2 !== 1'b1 || s2 !== 3'd0 || in2 !== 1'b1) begin
      n_fail++;
      $display("FAIL loops2_restart: got Busy=%b S=%0d In=%b want 1 0 1",
               busy2, s2, in2);
    end
    Start = 1'b0;
    Stop  = 1'b1;
    @(negedge Clk);
    Stop  = 1'b0;
  endtask

  task automatic test_mask_live();
    do_reset();
    Dir  = 1'b0;
    Mask = 8'hFF;
    start_pulse();
    n_checks++;
    if (in1 !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_on0: got In=%b want 1", in1);
    end
    Mask = 8'hFE;
    @(negedge Clk);
    n_checks++;
    if (in1 !== 1'b0 || busy1 !== 1'b1 || s1 !== 3'd0) begin
      n_fail++;
      $display("FAIL mask_blank: got In=%b Busy=%b S=%0d want 0 1 0",
               in1, busy1, s1);
    end
    Mask = 8'hFF;
    @(negedge Clk);
    n_checks++;
    if (in1 !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_on1: got In=%b want 1", in1);
    end
    Stop = 1'b1;
    @(negedge Clk);
    Stop = 1'b0;
  endtask

`ifdef SEG_CHASER_BOUNCE_EN
  task automatic test_bounce();
    logic [2:0] exp_s;
    int         idx;
    do_reset();
    Bounce = 1'b1;
    Dir    = 1'b0;
    Mask   = 8'hFF;
    start_pulse();
    for (int k = 0; k < 30; k++) begin
      idx   = k / 2;
      exp_s = (idx <= 7) ? 3'(idx) : 3'(14 - idx);
      n_checks++;
      if (sb !== exp_s || busyb !== 1'b1 || doneb !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_k%0d: got S=%0d Busy=%b Done=%b want S=%0d 1 0",
                 k, sb, busyb, doneb, exp_s);
      end
      @(negedge Clk);
    end
    n_checks++;
    if (doneb !== 1'b1 || sb !== 3'd0) begin
      n_fail++;
      $display("FAIL bounce_done: got Done=%b S=%0d want 1 0", doneb, sb);
    end
    Bounce = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    Start    = 1'b0;
    Stop     = 1'b0;
    Dir      = 1'b0;
    Mask     = 8'hFF;
`ifdef SEG_CHASER_BOUNCE_EN
    Bounce   = 1'b0;
`endif
    @(negedge Clk);
    test_reset();
    test_ascend();
    test_descend_mask();
    test_stop();
    test_back_to_back();
    test_mask_live();
`ifdef SEG_CHASER_BOUNCE_EN
    test_bounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
